// File: rtl/key_remap_config.sv
// Keyboard-remap configurator: learns a key-to-note permutation from the order of
// key presses and commits it atomically. It also supports abort, identity restore and map lookup.
module key_remap_config #(
  parameter int N_KEYS = 8,
  parameter int IDX_W  = 3
) (
  input  logic                      slow_clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [N_KEYS-1:0]         pose_buts,
  input  logic                      pose_esc,
  input  logic [IDX_W-1:0]          key_idx,
  output logic [IDX_W-1:0]          note_idx,
  output logic [N_KEYS*IDX_W-1:0]   perm_flat,
  output logic [IDX_W-1:0]          setting_cnt,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      aborted,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LEARN  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_PRESS = IDX_W'(N_KEYS - 2);
  localparam logic [IDX_W-1:0] LAST_NOTE  = IDX_W'(N_KEYS - 1);

  state_t             state, state_d;
  logic [IDX_W-1:0]   perm [N_KEYS];
  logic [IDX_W-1:0]   sh   [N_KEYS];
  logic [N_KEYS-1:0]  used;
  logic [IDX_W-1:0]   cnt;

  logic one_hot, hit_used;
  logic do_start, do_restore, do_abort, do_accept, do_reject, do_commit;

  assign one_hot  = (pose_buts != '0) &&
                    ((pose_buts & (pose_buts - N_KEYS'(1))) == '0);
  assign hit_used = |(pose_buts & used);

  // Priority within LEARN: escape, then a fresh single press, then any other press is an error.
  always_comb begin
    state_d    = state;
    do_start   = 1'b0;
    do_restore = 1'b0;
    do_abort   = 1'b0;
    do_accept  = 1'b0;
    do_reject  = 1'b0;
    do_commit  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          do_start = 1'b1;
          state_d  = S_LEARN;
        end else if (pose_esc) begin
          do_restore = 1'b1;
        end
      end
      S_LEARN: begin
        if (pose_esc) begin
          do_abort = 1'b1;
          state_d  = S_IDLE;
        end else if (one_hot && !hit_used) begin
          do_accept = 1'b1;
          if (cnt == LAST_PRESS) state_d = S_COMMIT;
        end else if (pose_buts != '0) begin
          do_reject = 1'b1;
        end
      end
      S_COMMIT: begin
        do_commit = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge slow_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      used    <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      aborted <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
        perm[i] <= IDX_W'(i);
        sh[i]   <= '0;
      end
    end else begin
      state   <= state_d;
      done    <= do_commit;
      err     <= do_reject;
      aborted <= do_abort;
      if (do_start || do_abort || do_commit) begin
        used <= '0;
        cnt  <= '0;
      end
      if (do_accept) begin
        for (int i = 0; i < N_KEYS; i++) begin
          if (pose_buts[i]) begin
            sh[i]   <= cnt;
            used[i] <= 1'b1;
          end
        end
        cnt <= cnt + IDX_W'(1);
      end
      if (do_restore) begin
        for (int i = 0; i < N_KEYS; i++) perm[i] <= IDX_W'(i);
      end
      // The one key never pressed takes the highest note, so perm stays a permutation.
      if (do_commit) begin
        for (int i = 0; i < N_KEYS; i++) perm[i] <= used[i] ? sh[i] : LAST_NOTE;
      end
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_flat
    assign perm_flat[g*IDX_W +: IDX_W] = perm[g];
  end

  assign note_idx    = perm[key_idx];
  assign setting_cnt = cnt;
  assign busy        = (state != S_IDLE);
  assign state_dbg   = state;

endmodule

// File: tb/tb_key_remap_config.sv
// Directed bench for key_remap_config: 8-key instance for the main scenarios and a
// 4-key instance for the small-parameter session.
module tb_key_remap_config;

  logic        slow_clk = 1'b0;
  logic        rst_n;
  logic        start, pose_esc;
  logic [7:0]  pose_buts;
  logic [2:0]  key_idx, note_idx, setting_cnt;
  logic [23:0] perm_flat;
  logic        busy, done, err, aborted;
  logic [1:0]  state_dbg;

  logic        start4, esc4;
  logic [3:0]  buts4;
  logic [1:0]  key_idx4, note_idx4, cnt4;
  logic [7:0]  perm4;
  logic        busy4, done4, err4, aborted4;
  logic [1:0]  state4;

  int checks = 0;
  int errors = 0;

  localparam logic [23:0] IDENT8 = 24'hFAC688;
  localparam logic [23:0] REV8   = 24'h053977;
  localparam logic [23:0] MIX8   = 24'h94F193;

  always #5 slow_clk = ~slow_clk;

  key_remap_config #(.N_KEYS(8), .IDX_W(3)) dut (
    .slow_clk(slow_clk), .rst_n(rst_n), .start(start), .pose_buts(pose_buts),
    .pose_esc(pose_esc), .key_idx(key_idx), .note_idx(note_idx), .perm_flat(perm_flat),
    .setting_cnt(setting_cnt), .busy(busy), .done(done), .err(err), .aborted(aborted),
    .state_dbg(state_dbg)
  );

  key_remap_config #(.N_KEYS(4), .IDX_W(2)) dut4 (
    .slow_clk(slow_clk), .rst_n(rst_n), .start(start4), .pose_buts(buts4),
    .pose_esc(esc4), .key_idx(key_idx4), .note_idx(note_idx4), .perm_flat(perm4),
    .setting_cnt(cnt4), .busy(busy4), .done(done4), .err(err4), .aborted(aborted4),
    .state_dbg(state4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge slow_clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic press(input int b);
    pose_buts    = '0;
    pose_buts[b] = 1'b1;
    tick();
    pose_buts = '0;
  endtask

  task automatic press_chk(input int b, input int exp_cnt);
    press(b);
    chk("press_cnt", 32'(setting_cnt), exp_cnt);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pose_esc = 1'b0; pose_buts = '0; key_idx = '0;
    start4 = 1'b0; esc4 = 1'b0; buts4 = '0; key_idx4 = '0;
    #23;
    rst_n = 1'b1;
    tick();

    // Reset state and lookup sweep
    chk("rst_perm", 32'(perm_flat), 32'(IDENT8));
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(setting_cnt), 0);
    chk("rst_flags", 32'({done, err, aborted}), 0);
    chk("rst_perm4", 32'(perm4), 32'h E4);
    for (int k = 0; k < 8; k++) begin
      key_idx = 3'(k);
      #1;
      chk("rst_lookup", 32'(note_idx), k);
    end

    // Presses in IDLE are ignored
    press(2);
    chk("idle_press_cnt", 32'(setting_cnt), 0);
    chk("idle_press_err", 32'(err), 0);

    // Full session 7..1, key 0 auto-fills
    do_start();
    chk("start_busy", 32'(busy), 1);
    for (int k = 7; k >= 2; k--) press_chk(k, 8 - k);
    press(1);
    chk("last_cnt", 32'(setting_cnt), 7);
    chk("last_busy", 32'(busy), 1);
    chk("last_done", 32'(done), 0);
    tick();
    chk("commit_done", 32'(done), 1);
    chk("commit_perm", 32'(perm_flat), 32'(REV8));
    chk("commit_busy", 32'(busy), 0);
    chk("commit_cnt", 32'(setting_cnt), 0);
    key_idx = 3'd0;
    #1;
    chk("commit_lookup0", 32'(note_idx), 7);
    tick();
    chk("done_pulse_end", 32'(done), 0);

    // Reset mid-session
    do_start();
    for (int k = 0; k < 4; k++) press_chk(k, k + 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_perm", 32'(perm_flat), 32'(IDENT8));
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_cnt", 32'(setting_cnt), 0);
    chk("midrst_flags", 32'({done, err, aborted}), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Session with a repeat press and a two-key press
    do_start();
    press_chk(3, 1);
    press(3);
    chk("repeat_err", 32'(err), 1);
    chk("repeat_cnt", 32'(setting_cnt), 1);
    tick();
    chk("repeat_err_end", 32'(err), 0);
    press_chk(5, 2);
    pose_buts = 8'b0001_0010;
    tick();
    pose_buts = '0;
    chk("multi_err", 32'(err), 1);
    chk("multi_cnt", 32'(setting_cnt), 2);
    tick();
    chk("multi_err_end", 32'(err), 0);
    press_chk(1, 3);
    press_chk(0, 4);
    press_chk(7, 5);
    press_chk(6, 6);
    press(2);
    tick();
    chk("mix_done", 32'(done), 1);
    chk("mix_perm", 32'(perm_flat), 32'(MIX8));
    key_idx = 3'd4;
    #1;
    chk("mix_lookup4", 32'(note_idx), 7);
    tick();

    // Abort with a simultaneous valid press
    do_start();
    for (int k = 0; k < 3; k++) press_chk(k, k + 1);
    pose_esc = 1'b1;
    pose_buts = 8'b0000_1000;
    tick();
    pose_esc = 1'b0;
    pose_buts = '0;
    chk("abort_pulse", 32'(aborted), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_cnt", 32'(setting_cnt), 0);
    chk("abort_perm", 32'(perm_flat), 32'(MIX8));
    chk("abort_done", 32'(done), 0);
    tick();
    chk("abort_pulse_end", 32'(aborted), 0);

    // start and escape together in IDLE: session starts, no restore
    start = 1'b1;
    pose_esc = 1'b1;
    tick();
    start = 1'b0;
    pose_esc = 1'b0;
    chk("startesc_busy", 32'(busy), 1);
    chk("startesc_perm", 32'(perm_flat), 32'(MIX8));
    pose_esc = 1'b1;
    tick();
    pose_esc = 1'b0;
    chk("esc_learn_abort", 32'(aborted), 1);
    chk("esc_learn_busy", 32'(busy), 0);
    tick();

    // Escape in IDLE restores identity without done
    pose_esc = 1'b1;
    tick();
    pose_esc = 1'b0;
    chk("restore_perm", 32'(perm_flat), 32'(IDENT8));
    chk("restore_done", 32'(done), 0);
    chk("restore_aborted", 32'(aborted), 0);
    chk("restore_busy", 32'(busy), 0);
    tick();

    // Four-key instance: keys 2,0,1 then key 3 auto-fills
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    buts4 = 4'b0100;
    tick();
    chk("n4_cnt1", 32'(cnt4), 1);
    buts4 = 4'b0001;
    tick();
    chk("n4_cnt2", 32'(cnt4), 2);
    buts4 = 4'b0010;
    tick();
    buts4 = '0;
    chk("n4_busy_commit", 32'(busy4), 1);
    tick();
    chk("n4_done", 32'(done4), 1);
    chk("n4_perm", 32'(perm4), 32'h C9);
    chk("n4_busy", 32'(busy4), 0);
    key_idx4 = 2'd0;
    #1;
    chk("n4_lookup0", 32'(note_idx4), 1);
    tick();
    chk("n4_done_end", 32'(done4), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_remap_config.md
# key_remap_config

Parametrised keyboard-remap configurator for the electronic organ. When the player starts a learn session, the block records the order in which the N_KEYS debounced key buttons are pressed. It builds a key-to-note permutation from that order and commits it atomically. It also supports abort, duplicate-press rejection, identity restore and a registered-map lookup port. It sits between the button debouncer/edge detector and the note generator, which reads the committed map.

## Interface
Parameters:
- N_KEYS, 8, number of keys/notes; legal range 2..16.
- IDX_W, 3, index width; must equal ceil(log2(N_KEYS)).

Ports:
- slow_clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a learn session.
- pose_buts  in  N_KEYS  key press pulses, one cycle per press, already debounced.
- pose_esc  in  1  single-cycle escape pulse.
- key_idx  in  IDX_W  physical key to look up.
- note_idx  out  IDX_W  committed note for key_idx: perm[key_idx], combinational from committed registers.
- perm_flat  out  N_KEYS*IDX_W  committed map; bits [i*IDX_W +: IDX_W] hold the note for key i.
- setting_cnt  out  IDX_W  number of keys assigned so far in the current session.
- busy  out  1  high in LEARN and COMMIT.
- done  out  1  one-cycle pulse when a new map is committed.
- err  out  1  one-cycle pulse when a press is rejected.
- aborted  out  1  one-cycle pulse when a session is cancelled.

## Operation
- Storage:
  - committed perm[N_KEYS] of IDX_W bits each.
  - shadow sh[N_KEYS] of IDX_W bits each.
  - used mask of N_KEYS bits.
  - cnt of IDX_W bits; setting_cnt = cnt.
- States: IDLE, LEARN, COMMIT.
- IDLE:
  - start=1: clear used, clear cnt, go to LEARN. pose_buts is ignored that cycle.
  - pose_esc=1 without start: perm[i] := i (identity restore). No done pulse, state stays IDLE. If start and pose_esc are both high, start wins.
  - pose_buts is ignored in IDLE.
- LEARN, priority order per cycle:
  1. pose_esc=1: abort to IDLE. perm is unchanged, used and cnt are cleared, aborted pulses.
  2. pose_buts one-hot at bit b with used[b]=0: sh[b] := cnt, used[b] := 1, cnt := cnt+1. If cnt == N_KEYS-2 before the increment (this is the (N_KEYS-1)-th distinct key), go to COMMIT.
  3. pose_buts one-hot at bit b with used[b]=1, or pose_buts with two or more bits set: err pulses, no state change.
  4. pose_buts == 0: hold.
  - start is ignored in LEARN and in COMMIT.
- COMMIT (exactly one cycle):
  - The single key with used=0 is auto-assigned note N_KEYS-1.
  - perm := sh (with the auto-fill), all N_KEYS entries written on the same edge.
  - done pulses, cnt := 0, used := 0, go to IDLE.
  - pose_esc, pose_buts and start are ignored in COMMIT.
- Result: the k-th distinct key pressed (0-based) plays note k, and the last untouched key plays note N_KEYS-1. perm is always a valid permutation.
- Arithmetic: cnt never exceeds N_KEYS-1; no wrap can occur.

## Timing
- Reset values:
  - perm[i] = i (perm_flat is the identity map).
  - setting_cnt = 0.
  - busy, done, err, aborted = 0.
  - State = IDLE; used = 0; sh = 0.
- Press latency: setting_cnt updates one edge after the press cycle.
- Commit timing, with the last accepted press in cycle t:
  - COMMIT state during cycle t+1.
  - perm_flat and done change at the edge ending t+1; done is high during t+2.
  - busy falls at the same edge.
- Flag timing: err and aborted are registered and high for the one cycle after the offending or escape input.
- busy rises one edge after start.
- note_idx follows key_idx combinationally and reflects perm from the edge at which it is written.
- Reset asserted mid-session: all registers, including perm, return immediately to their reset values and the session is lost.

## Test plan
- Reset, then sweep key_idx 0..7 -> note_idx = 0..7, busy=0, setting_cnt=0.
- start, then presses on keys 7,6,5,4,3,2,1, one per cycle with idle gaps -> setting_cnt steps 1..7 after each, then COMMIT. Key 0 auto-fills to 7. Result: perm = {7:0, 6:1, 5:2, 4:3, 3:4, 2:5, 1:6, 0:7}, done is one pulse two cycles after the last press, busy=0.
- Mid-session: repeat-press key 3 and separately press 8'b00010010 -> err is one pulse each time, setting_cnt unchanged, final map identical to the same session without those presses.
- start, 3 presses, then pose_esc -> aborted pulse, perm unchanged from the previous commit, setting_cnt=0, busy=0. A pose_esc in IDLE afterwards -> identity map restored with no done pulse.
- Simultaneous events: pose_esc together with a valid press in LEARN -> abort wins and no assignment is made; start together with pose_esc in IDLE -> session starts and the map is not restored.
- rst_n pulsed low after 4 presses -> identity map and all flags 0 immediately; the next session behaves normally. Repeat the second scenario with N_KEYS=4, IDX_W=2 (keys 2,0,1 -> perm {2:0, 0:1, 1:2, 3:3}).
